// File: rtl/ai_dma_stream_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ai_dma_pkg
//  Description : Shared types and helpers for the speech-pipeline DMA
//                stream loader. Holds the FSM state encoding, memory word
//                geometry and the sample-window shift clamp.
//  Revision    : 1.0  initial release
// ============================================================================
package ai_dma_pkg;

    localparam int unsigned c_BYTES_PER_WORD = 4;
    localparam int unsigned c_HALF_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Keeps the extracted window inside its 16-bit half: s = min(shift, 16 - sample_w)
    function automatic logic [4:0] clamp_shift(input logic [3:0] shift,
                                               input int unsigned sample_w);
        logic [4:0] w_max;
        w_max = 5'(c_HALF_W - sample_w);
        return ({1'b0, shift} > w_max) ? w_max : {1'b0, shift};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ai_dma_stream_loader_beat_packer.sv
`default_nettype none
// ============================================================================
//  Module      : ai_dma_beat_packer
//  Description : Lane register bank for one stream beat. Each captured
//                memory word contributes two sample windows (low half to the
//                even lane, high half to the odd lane). Lanes are zeroed on
//                clear so a short final beat carries zeros in unused lanes.
//  Revision    : 1.0  initial release
// ============================================================================
module ai_dma_beat_packer
    import ai_dma_pkg::*;
#(
    parameter  int unsigned SAMPLE_W       = 8,
    parameter  int unsigned WORDS_PER_BEAT = 2,
    localparam int unsigned BEAT_W         = WORDS_PER_BEAT * 2 * SAMPLE_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              capture,
    input  logic [1:0]        index,
    input  logic [3:0]        shift,
    input  logic [31:0]       word,
    output logic [BEAT_W-1:0] beat
);

    localparam int unsigned c_LANES = 2 * WORDS_PER_BEAT;

    logic [SAMPLE_W-1:0] r_lane [c_LANES];
    logic [4:0]          w_s;
    logic [15:0]         w_lo;
    logic [15:0]         w_hi;

    assign w_s  = clamp_shift(shift, SAMPLE_W);
    assign w_lo = word[15:0]  >> w_s;
    assign w_hi = word[31:16] >> w_s;

    // Lane bank: clear has priority, otherwise write the word's lane pair at index
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < c_LANES; i++) begin
                r_lane[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < WORDS_PER_BEAT; i++) begin
                if (index == 2'(i)) begin
                    r_lane[2*i]   <= w_lo[SAMPLE_W-1:0];
                    r_lane[2*i+1] <= w_hi[SAMPLE_W-1:0];
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < c_LANES; g++) begin : g_pack
            assign beat[g*SAMPLE_W +: SAMPLE_W] = r_lane[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ai_dma_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ai_dma_stream_loader
//  Description : Reads two-sample words from a memory ring buffer, packs the
//                sample windows into Avalon-ST beats, frames one packet per
//                start request and pulses irq when the packet completes.
//  Revision    : 1.0  initial release
// ============================================================================
module ai_dma_stream_loader
    import ai_dma_pkg::*;
#(
    parameter  int unsigned ADDR_W         = 32,
    parameter  int unsigned SAMPLE_W       = 8,
    parameter  int unsigned WORDS_PER_BEAT = 2,
    parameter  int unsigned LEN_W          = 16,
    localparam int unsigned BEAT_W         = WORDS_PER_BEAT * 2 * SAMPLE_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        cfg_shift,
    input  logic [ADDR_W-1:0] start_addr_read,
    input  logic [ADDR_W-1:0] start_addr_block,
    input  logic [ADDR_W-1:0] stop_addr_block,
    input  logic [LEN_W-1:0]  data_len,
    output logic              busy,
    output logic              irq,
    output logic              avs_m1_valid,
    output logic              avs_m1_startofpacket,
    output logic              avs_m1_endofpacket,
    output logic [BEAT_W-1:0] avs_m1_data,
    input  logic              avs_m1_ready,
    output logic [ADDR_W-1:0] dma1_addr,
    output logic              dma1_read,
    input  logic [31:0]       dma1_readdata,
    input  logic              dma1_rdy
);

    // staged inputs
    logic              r_start, r_abort;
    logic [3:0]        r_cfg_shift;
    logic [ADDR_W-1:0] r_start_addr_read, r_start_addr_block, r_stop_addr_block;
    logic [LEN_W-1:0]  r_data_len;

    // working registers
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr, r_block, r_stop;
    logic [LEN_W-1:0]  r_len;
    logic [3:0]        r_shift;
    logic [LEN_W:0]    r_count;       // one extra bit so count+4 never wraps
    logic [1:0]        r_index;
    logic              r_sop, r_abort_pend;
    logic              r_busy, r_irq, r_read, r_valid;

    logic [LEN_W:0]    w_count_inc;
    logic              w_last_word, w_eop, w_abort_any, w_clear, w_capture;
    logic [BEAT_W-1:0] w_beat;

    assign w_count_inc = r_count + (LEN_W+1)'(c_BYTES_PER_WORD);
    assign w_last_word = (w_count_inc >= {1'b0, r_len});
    assign w_eop       = (r_count >= {1'b0, r_len});
    assign w_abort_any = r_abort || r_abort_pend;
    assign w_clear     = ((r_state == ST_IDLE) && r_start) ||
                         ((r_state == ST_SEND) && avs_m1_ready && !r_abort);
    assign w_capture   = (r_state == ST_WAIT) && dma1_rdy && !w_abort_any;

    // One register stage on every control and configuration input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start            <= 1'b0;
            r_abort            <= 1'b0;
            r_cfg_shift        <= '0;
            r_start_addr_read  <= '0;
            r_start_addr_block <= '0;
            r_stop_addr_block  <= '0;
            r_data_len         <= '0;
        end else begin
            r_start            <= start;
            r_abort            <= abort;
            r_cfg_shift        <= cfg_shift;
            r_start_addr_read  <= start_addr_read;
            r_start_addr_block <= start_addr_block;
            r_stop_addr_block  <= stop_addr_block;
            r_data_len         <= data_len;
        end
    end

    // Packet sequencer: outputs are registered and set on the transition into a state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_block      <= '0;
            r_stop       <= '0;
            r_len        <= '0;
            r_shift      <= '0;
            r_count      <= '0;
            r_index      <= '0;
            r_sop        <= 1'b0;
            r_abort_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_irq        <= 1'b0;
            r_read       <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_read <= 1'b0;
            r_irq  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_start) begin
                        r_addr       <= r_start_addr_read;
                        r_block      <= r_start_addr_block;
                        r_stop       <= r_stop_addr_block;
                        r_len        <= r_data_len;
                        r_shift      <= r_cfg_shift;
                        r_count      <= '0;
                        r_index      <= '0;
                        r_sop        <= 1'b1;
                        r_abort_pend <= 1'b0;
                        r_busy       <= 1'b1;
                        if (r_data_len == '0) begin
                            r_state <= ST_DONE;
                            r_irq   <= 1'b1;
                        end else begin
                            r_state <= ST_REQ;
                            r_read  <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (r_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // an outstanding read must complete before an abort can take effect
                    if (dma1_rdy) begin
                        if (w_abort_any) begin
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                            r_abort_pend <= 1'b0;
                        end else begin
                            r_count <= w_count_inc;
                            r_addr  <= (r_addr == r_stop) ? r_block
                                                          : r_addr + ADDR_W'(c_BYTES_PER_WORD);
                            if ((r_index == 2'(WORDS_PER_BEAT-1)) || w_last_word) begin
                                r_state <= ST_SEND;
                                r_valid <= 1'b1;
                            end else begin
                                r_index <= r_index + 2'd1;
                                r_state <= ST_REQ;
                                r_read  <= 1'b1;
                            end
                        end
                    end else if (r_abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (r_abort) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (avs_m1_ready) begin
                        r_valid <= 1'b0;
                        r_sop   <= 1'b0;
                        r_index <= '0;
                        if (w_eop) begin
                            r_state <= ST_DONE;
                            r_irq   <= 1'b1;
                        end else begin
                            r_state <= ST_REQ;
                            r_read  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    ai_dma_beat_packer #(
        .SAMPLE_W       (SAMPLE_W),
        .WORDS_PER_BEAT (WORDS_PER_BEAT)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .capture (w_capture),
        .index   (r_index),
        .shift   (r_shift),
        .word    (dma1_readdata),
        .beat    (w_beat)
    );

    assign busy                 = r_busy;
    assign irq                  = r_irq;
    assign dma1_read            = r_read;
    assign dma1_addr            = r_read ? r_addr : '0;
    assign avs_m1_valid         = r_valid;
    assign avs_m1_startofpacket = r_valid & r_sop;
    assign avs_m1_endofpacket   = r_valid & w_eop;
    assign avs_m1_data          = r_valid ? w_beat : '0;

endmodule
`default_nettype wire

// File: tb/tb_ai_dma_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ai_dma_stream_loader
//  Description : Directed self-checking bench for ai_dma_stream_loader with
//                a word-addressed memory responder and a stream monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ai_dma_stream_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [3:0]  cfg_shift = '0;
    logic [31:0] start_addr_read = '0, start_addr_block = '0, stop_addr_block = '0;
    logic [15:0] data_len = '0;
    logic        busy, irq, valid, sop, eop;
    logic [31:0] data;
    logic        ready = 1'b1;
    logic [31:0] dma1_addr;
    logic        dma1_read;
    logic [31:0] dma1_readdata = '0;
    logic        dma1_rdy = 1'b0;

    int checks = 0, failures = 0;
    int cyc = 0, c0 = 0;

    ai_dma_stream_loader u_dut (
        .clk (clk), .rst (rst), .start (start), .abort (abort),
        .cfg_shift (cfg_shift), .start_addr_read (start_addr_read),
        .start_addr_block (start_addr_block), .stop_addr_block (stop_addr_block),
        .data_len (data_len), .busy (busy), .irq (irq),
        .avs_m1_valid (valid), .avs_m1_startofpacket (sop),
        .avs_m1_endofpacket (eop), .avs_m1_data (data), .avs_m1_ready (ready),
        .dma1_addr (dma1_addr), .dma1_read (dma1_read),
        .dma1_readdata (dma1_readdata), .dma1_rdy (dma1_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // memory model
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hDEADBEEF;
    endfunction

    // read responder: rdy arrives rdy_delay cycles after the first WAIT cycle
    int          rdy_delay = 0, wait_left = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    always @(posedge clk) begin
        dma1_rdy <= 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else if (dma1_read) begin
            if (rdy_delay == 0) begin
                dma1_rdy      <= 1'b1;
                dma1_readdata <= memrd(dma1_addr);
            end else begin
                pend = 1'b1; wait_left = rdy_delay; pend_addr = dma1_addr;
            end
        end else if (pend) begin
            wait_left--;
            if (wait_left == 0) begin
                pend = 1'b0;
                dma1_rdy      <= 1'b1;
                dma1_readdata <= memrd(pend_addr);
            end
        end
    end

    // stream / irq / read monitor
    logic [31:0] bq_data [$];
    logic [1:0]  bq_flag [$];
    int          bq_cyc  [$];
    logic [31:0] addr_q  [$];
    int          irq_cnt = 0, irq_cyc = 0, rd_first_cyc = 0, valid_cnt = 0, stab_err = 0;
    logic        stall_prev = 1'b0;
    logic [33:0] held = '0;
    always @(negedge clk) begin
        if (valid) valid_cnt++;
        if (valid && ready) begin
            bq_data.push_back(data); bq_flag.push_back({sop, eop}); bq_cyc.push_back(cyc);
        end
        if (irq) begin irq_cnt++; irq_cyc = cyc; end
        if (dma1_read) begin
            if (addr_q.size() == 0) rd_first_cyc = cyc;
            addr_q.push_back(dma1_addr);
        end
        if (stall_prev && (!valid || {sop, eop, data} !== held)) stab_err++;
        stall_prev = valid && !ready;
        held       = {sop, eop, data};
    end

    function automatic logic [63:0] bdat(input int i);
        return (i < bq_data.size()) ? 64'(bq_data[i]) : 64'hBAD0BAD0BAD;
    endfunction
    function automatic logic [63:0] bflg(input int i);
        return (i < bq_flag.size()) ? 64'(bq_flag[i]) : 64'hF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bq_data.delete(); bq_flag.delete(); bq_cyc.delete(); addr_q.delete();
        irq_cnt = 0; irq_cyc = 0; rd_first_cyc = 0; valid_cnt = 0; stab_err = 0;
    endtask

    task automatic cfg(input logic [3:0] sh, input logic [31:0] sa, input logic [31:0] blk,
                       input logic [31:0] stp, input logic [15:0] len);
        cfg_shift = sh; start_addr_read = sa; start_addr_block = blk;
        stop_addr_block = stp; data_len = len;
    endtask

    task automatic pulse_start();
        start = 1'b1; c0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < max) begin @(negedge clk); n++; end
        chk({tag, "_idle_timeout"}, busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_read(input string tag, input int max);
        int n = 0;
        while (!dma1_read && n < max) begin @(negedge clk); n++; end
        chk({tag, "_read_timeout"}, dma1_read, 1'b1);
    endtask

    logic [31:0] ring_exp [4] = '{32'h1FC, 32'h100, 32'h104, 32'h108};

    initial begin
        mem[32'h100] = 32'h00AA00BB;  mem[32'h104] = 32'h00CC00DD;
        mem[32'h108] = 32'h00EE00FF;  mem[32'h1FC] = 32'h00120034;
        mem[32'h200] = 32'h03FC0FF0;  mem[32'h300] = 32'hAB12CD34;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ctl", {irq, valid, sop, eop, dma1_read}, 5'b0);
        chk("rst_data", data, 32'h0);
        chk("rst_addr", dma1_addr, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic two-word beat, latency and irq timing
        cfg(4'd0, 32'h100, 32'h0, 32'hFFFF_FFFC, 16'd8); clr(); pulse_start();
        wait_idle("t1", 40);
        chk("t1_nbeats", bq_data.size(), 1);
        chk("t1_data", bdat(0), 32'hCCDDAABB);
        chk("t1_sop_eop", bflg(0), 2'b11);
        chk("t1_read_latency", rd_first_cyc - c0, 2);
        chk("t1_beat_cycle", (bq_cyc.size() > 0) ? bq_cyc[0] - c0 : -1, 6);
        chk("t1_irq_cnt", irq_cnt, 1);
        chk("t1_irq_after_eop", (bq_cyc.size() > 0) ? irq_cyc - bq_cyc[0] : -1, 1);
        chk("t1_nreads", addr_q.size(), 2);
        chk("t1_addr1", (addr_q.size() > 1) ? addr_q[1] : 32'hX, 32'h104);

        // shift window
        cfg(4'd2, 32'h200, 32'h0, 32'hFFFF_FFFC, 16'd4); clr(); pulse_start();
        wait_idle("t2", 40);
        chk("t2_data", bdat(0), 32'h0000FFFC);
        chk("t2_sop_eop", bflg(0), 2'b11);

        // shift clamped to 16-SAMPLE_W, partial-word length rounds up
        cfg(4'd12, 32'h300, 32'h0, 32'hFFFF_FFFC, 16'd1); clr(); pulse_start();
        wait_idle("t3", 40);
        chk("t3_data", bdat(0), 32'h0000ABCD);
        chk("t3_nreads", addr_q.size(), 1);

        // ring wrap
        cfg(4'd0, 32'h1FC, 32'h100, 32'h1FC, 16'd16); clr(); pulse_start();
        wait_idle("t4", 60);
        chk("t4_nreads", addr_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t4_addr%0d", i), (i < addr_q.size()) ? addr_q[i] : 32'hX, ring_exp[i]);
        chk("t4_beat0", bdat(0), 32'hAABB1234);
        chk("t4_flag0", bflg(0), 2'b10);
        chk("t4_beat1", bdat(1), 32'hEEFFCCDD);
        chk("t4_flag1", bflg(1), 2'b01);

        // short final beat, start while busy is ignored
        cfg(4'd0, 32'h100, 32'h0, 32'hFFFF_FFFC, 16'd12); clr(); pulse_start();
        repeat (4) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_idle("t5", 60);
        chk("t5_nbeats", bq_data.size(), 2);
        chk("t5_beat0", bdat(0), 32'hCCDDAABB);
        chk("t5_flag0", bflg(0), 2'b10);
        chk("t5_beat1", bdat(1), 32'h0000EEFF);
        chk("t5_flag1", bflg(1), 2'b01);
        chk("t5_nreads", addr_q.size(), 3);
        chk("t5_irq_cnt", irq_cnt, 1);

        // backpressure: beat held stable while ready is low
        ready = 1'b0;
        cfg(4'd0, 32'h100, 32'h0, 32'hFFFF_FFFC, 16'd8); clr(); pulse_start();
        begin
            int n = 0;
            while (!valid && n < 20) begin @(negedge clk); n++; end
        end
        chk("t6_valid_seen", valid, 1'b1);
        repeat (5) @(negedge clk);
        chk("t6_valid_held", valid, 1'b1);
        chk("t6_data_held", data, 32'hCCDDAABB);
        chk("t6_flags_held", {sop, eop}, 2'b11);
        chk("t6_no_accept", bq_data.size(), 0);
        ready = 1'b1;
        wait_idle("t6", 20);
        chk("t6_stable", stab_err, 0);
        chk("t6_nbeats", bq_data.size(), 1);
        chk("t6_irq_cnt", irq_cnt, 1);

        // abort during WAIT: held until rdy, then idle without valid or irq
        rdy_delay = 4;
        cfg(4'd0, 32'h100, 32'h0, 32'hFFFF_FFFC, 16'd8); clr(); pulse_start();
        wait_read("t7", 10);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("t7_busy_held", busy, 1'b1);
        wait_idle("t7", 20);
        chk("t7_irq_cnt", irq_cnt, 0);
        chk("t7_valid_cnt", valid_cnt, 0);
        chk("t7_nreads", addr_q.size(), 1);
        rdy_delay = 0;

        // zero length: no reads, irq two cycles after start
        cfg(4'd0, 32'h100, 32'h0, 32'hFFFF_FFFC, 16'd0); clr(); pulse_start();
        wait_idle("t8", 20);
        chk("t8_nreads", addr_q.size(), 0);
        chk("t8_irq_cnt", irq_cnt, 1);
        chk("t8_irq_cycle", irq_cyc - c0, 2);
        chk("t8_valid_cnt", valid_cnt, 0);

        // reset in the middle of WAIT
        rdy_delay = 3;
        cfg(4'd0, 32'h100, 32'h0, 32'hFFFF_FFFC, 16'd8); clr(); pulse_start();
        wait_read("t9", 10);
        @(negedge clk);
        rst = 1'b1; @(negedge clk);
        chk("t9_busy", busy, 1'b0);
        chk("t9_ctl", {irq, valid, sop, eop, dma1_read}, 5'b0);
        chk("t9_addr", dma1_addr, 32'h0);
        rst = 1'b0; rdy_delay = 0;
        repeat (6) @(negedge clk);

        // recovery after reset
        cfg(4'd2, 32'h200, 32'h0, 32'hFFFF_FFFC, 16'd4); clr(); pulse_start();
        wait_idle("t10", 40);
        chk("t10_data", bdat(0), 32'h0000FFFC);
        chk("t10_irq_cnt", irq_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
